// File: rtl/core_pkg.sv
// Shared core types: the fetched-instruction record passed from IF to ID and the canonical NOP.
// Pure type/constant package, no timing or flow control of its own.
package core_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/id_instr_queue.sv
// IF->ID fetch queue: DEPTH-entry FIFO, head registered (push visible at ID one cycle later), NOP bubble when empty.
// Backpressure: ready_if_o depends only on occupancy; a pop on a full queue frees the slot for the following cycle.
module id_instr_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                pc_if_i,
  input  logic [31:0]                instr_if_i,
  input  logic                       fault_if_i,
  input  logic                       valid_if_i,
  output logic                       ready_if_o,
  output logic [31:0]                pc_id_o,
  output logic [31:0]                instr_id_o,
  output logic                       fault_id_o,
  output logic                       valid_id_o,
  input  logic                       ready_id_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     storage_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  fetch_entry_t entry_in;
  fetch_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = valid_if_i && !full;
  assign pop   = !empty && ready_id_i;

  assign entry_in = '{pc: pc_if_i, instr: instr_if_i, fault: fault_if_i};
  assign head     = storage_q[rd_ptr_q];

  // Data storage: only reset clears it; a flush just abandons the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};
      end
    end else if (push && !flush_i) begin
      storage_q[wr_ptr_q] <= entry_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign ready_if_o = !full;
  assign valid_id_o = !empty;
  assign pc_id_o    = head.pc;
  assign instr_id_o = empty ? NOP_INSTR : head.instr;
  assign fault_id_o = !empty && head.fault;
  assign count_o    = count_q;

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full));

  a_count_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_FULL);

  a_nop_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    !valid_id_o |-> (instr_id_o == NOP_INSTR));

endmodule

// File: tb/tb_id_instr_queue.sv
// Bench for id_instr_queue: vector table on a DEPTH=2 instance, scoreboarded streaming on a DEPTH=3 instance.
module tb_id_instr_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic [31:0] pc_if, instr_if, pc_id, instr_id;
  logic        fault_if, valid_if, ready_if, fault_id, valid_id, ready_id, flush;
  logic [1:0]  count;

  // DEPTH=3 instance
  logic [31:0] s_pc_if, s_instr_if, s_pc_id, s_instr_id;
  logic        s_fault_if, s_valid_if, s_ready_if, s_fault_id, s_valid_id, s_ready_id, s_flush;
  logic [1:0]  s_count;

  id_instr_queue #(.DEPTH(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .pc_if_i(pc_if), .instr_if_i(instr_if), .fault_if_i(fault_if),
    .valid_if_i(valid_if), .ready_if_o(ready_if),
    .pc_id_o(pc_id), .instr_id_o(instr_id), .fault_id_o(fault_id),
    .valid_id_o(valid_id), .ready_id_i(ready_id),
    .flush_i(flush), .count_o(count)
  );

  id_instr_queue #(.DEPTH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .pc_if_i(s_pc_if), .instr_if_i(s_instr_if), .fault_if_i(s_fault_if),
    .valid_if_i(s_valid_if), .ready_if_o(s_ready_if),
    .pc_id_o(s_pc_id), .instr_id_o(s_instr_id), .fault_id_o(s_fault_id),
    .valid_id_o(s_valid_id), .ready_id_i(s_ready_id),
    .flush_i(s_flush), .count_o(s_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, flush, vif, rid;
    logic [31:0] pc, instr;
    logic        flt;
    int          e_cnt;
    logic        e_vld, e_rif, chk_pc;
    logic [31:0] e_pc, e_instr;
    logic        e_flt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic vi, input logic ri,
                              input logic [31:0] p, input logic [31:0] ins, input logic fl,
                              input int ec, input logic ev, input logic erif, input logic cp,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ef);
    vec_t v;
    v.rst = r; v.flush = f; v.vif = vi; v.rid = ri;
    v.pc = p; v.instr = ins; v.flt = fl;
    v.e_cnt = ec; v.e_vld = ev; v.e_rif = erif; v.chk_pc = cp;
    v.e_pc = ep; v.e_instr = ei; v.e_flt = ef;
    return v;
  endfunction

  vec_t vecs[20];

  logic [31:0] sbq[$];

  initial begin
    int sent, got, mcnt;
    logic pop_m, push_m;
    logic [31:0] exp_pc;

    // Expected values describe the state after the clock edge that consumes the inputs.
    vecs[0]  = mk(0,0,0,0, 32'h0,   32'h0,        0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[1]  = mk(0,0,1,0, 32'h100, 32'h00500093, 0, 1,1,1, 1,32'h100,32'h00500093, 0);
    vecs[2]  = mk(0,0,1,0, 32'h104, 32'h00a00113, 0, 2,1,0, 1,32'h100,32'h00500093, 0);
    vecs[3]  = mk(0,0,1,0, 32'h108, 32'h00f00193, 0, 2,1,0, 1,32'h100,32'h00500093, 0);
    vecs[4]  = mk(0,0,1,0, 32'h108, 32'h00f00193, 0, 2,1,0, 1,32'h100,32'h00500093, 0);
    vecs[5]  = mk(0,0,1,1, 32'h108, 32'h00f00193, 0, 1,1,1, 1,32'h104,32'h00a00113, 0);
    vecs[6]  = mk(0,0,1,0, 32'h108, 32'h00f00193, 0, 2,1,0, 1,32'h104,32'h00a00113, 0);
    vecs[7]  = mk(0,0,0,1, 32'h0,   32'h0,        0, 1,1,1, 1,32'h108,32'h00f00193, 0);
    vecs[8]  = mk(0,0,0,1, 32'h0,   32'h0,        0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[9]  = mk(0,0,0,1, 32'h0,   32'h0,        0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[10] = mk(0,0,1,0, 32'h300, 32'h00000073, 1, 1,1,1, 1,32'h300,32'h00000073, 1);
    vecs[11] = mk(0,0,0,1, 32'h0,   32'h0,        0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[12] = mk(0,0,1,0, 32'h400, 32'h00100213, 0, 1,1,1, 1,32'h400,32'h00100213, 0);
    vecs[13] = mk(0,0,1,0, 32'h404, 32'h00200293, 0, 2,1,0, 1,32'h400,32'h00100213, 0);
    vecs[14] = mk(0,1,1,1, 32'h408, 32'h00300313, 0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[15] = mk(0,0,1,0, 32'h600, 32'h00600493, 0, 1,1,1, 1,32'h600,32'h00600493, 0);
    vecs[16] = mk(0,0,0,1, 32'h0,   32'h0,        0, 0,0,1, 0,32'h0,  NOP,          0);
    vecs[17] = mk(0,0,1,0, 32'h500, 32'h00400393, 0, 1,1,1, 1,32'h500,32'h00400393, 0);
    vecs[18] = mk(0,0,1,0, 32'h504, 32'h00500413, 0, 2,1,0, 1,32'h500,32'h00400393, 0);
    vecs[19] = mk(1,0,1,1, 32'h508, 32'h00700513, 0, 0,0,1, 1,32'h0,  NOP,          0);

    rst = 1'b1;
    pc_if = '0; instr_if = '0; fault_if = 1'b0; valid_if = 1'b0; ready_id = 1'b0; flush = 1'b0;
    s_pc_if = '0; s_instr_if = '0; s_fault_if = 1'b0; s_valid_if = 1'b0; s_ready_id = 1'b0; s_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_count",    32'(count),    32'd0);
    check("rst_valid",    32'(valid_id), 32'd0);
    check("rst_ready_if", 32'(ready_if), 32'd1);
    check("rst_instr",    instr_id,      NOP);
    check("rst_fault",    32'(fault_id), 32'd0);
    check("rst_pc",       pc_id,         32'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush;
      valid_if = vecs[i].vif; ready_id = vecs[i].rid;
      pc_if = vecs[i].pc; instr_if = vecs[i].instr; fault_if = vecs[i].flt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].e_cnt));
      check($sformatf("v%0d_valid", i),    32'(valid_id), 32'(vecs[i].e_vld));
      check($sformatf("v%0d_ready_if", i), 32'(ready_if), 32'(vecs[i].e_rif));
      check($sformatf("v%0d_instr", i),    instr_id,      vecs[i].e_instr);
      check($sformatf("v%0d_fault", i),    32'(fault_id), 32'(vecs[i].e_flt));
      if (vecs[i].chk_pc) begin
        check($sformatf("v%0d_pc", i), pc_id, vecs[i].e_pc);
      end
    end

    rst = 1'b0; flush = 1'b0; valid_if = 1'b0; ready_id = 1'b0;

    // Streaming through DEPTH=3: eight pushes, ready_id toggling 1,0,1,0...
    sent = 0; got = 0; mcnt = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      s_valid_if = (sent < 8);
      s_pc_if    = 32'h200 + 32'(sent) * 32'd4;
      s_instr_if = 32'hA000_0000 | s_pc_if;
      s_ready_id = ((cyc % 2) == 0);
      check($sformatf("s%0d_valid", cyc),    32'(s_valid_id), 32'(mcnt != 0));
      check($sformatf("s%0d_ready_if", cyc), 32'(s_ready_if), 32'(mcnt != 3));
      pop_m  = (mcnt != 0) && s_ready_id;
      push_m = s_valid_if && (mcnt != 3);
      if (pop_m) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s%0d_underflow: got a pop, expected empty scoreboard", cyc);
        end else begin
          exp_pc = sbq.pop_front();
          check($sformatf("s%0d_pc", cyc),    s_pc_id,    exp_pc);
          check($sformatf("s%0d_instr", cyc), s_instr_id, 32'hA000_0000 | exp_pc);
          got++;
        end
      end
      if (push_m) begin
        sbq.push_back(s_pc_if);
        sent++;
      end
      mcnt = mcnt + int'(push_m) - int'(pop_m);
      @(posedge clk);
      #1;
      check($sformatf("s%0d_count", cyc), 32'(s_count), 32'(mcnt));
    end
    s_valid_if = 1'b0; s_ready_id = 1'b0;

    n_cmp++;
    if (got != 8) begin
      n_err++;
      $display("FAIL stream_drain: got %0d entries, expected 8", got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
